led_fade_sequencer: RTL

- Autonomous bus master that drives triangle-wave "breathing" fades on the LED controller.
- Writes REG_LEDOUT once at start, then periodically rewrites REG_PWM0..3 over the register bus.
- Shares the bus with the host through a request/grant handshake; the host always wins at a transaction boundary.
- Sits between the top-level host bus mux and led_controller, clocked from clk_400K.

---
 rtl/led_driver_pkg.sv | 30 +++
 rtl/fade_prescaler.sv | 43 ++++
 rtl/led_fade_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/led_driver_pkg.sv
// Shared LED-driver types: register map, data width and the fade sequencer's state/direction encodings.
package led_driver_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [3:0] {
    REG_MODE1   = 4'h0,
    REG_MODE2   = 4'h1,
    REG_PWM0    = 4'h2,
    REG_PWM1    = 4'h3,
    REG_PWM2    = 4'h4,
    REG_PWM3    = 4'h5,
    REG_GRPPWM  = 4'h6,
    REG_GRPFREQ = 4'h7,
    REG_LEDOUT  = 4'h8
  } reg_enum_t;

  typedef enum logic [2:0] {
    FS_IDLE       = 3'd0,
    FS_INIT_SETUP = 3'd1,
    FS_INIT_WEN   = 3'd2,
    FS_WAIT_TICK  = 3'd3,
    FS_CH_SETUP   = 3'd4,
    FS_CH_WEN     = 3'd5
  } fade_state_e;

  localparam logic FADE_DIR_UP   = 1'b0;
  localparam logic FADE_DIR_DOWN = 1'b1;

endpackage

// File: rtl/fade_prescaler.sv
// Divides clk_400K into a one-cycle fade tick while enabled; ticks the sequencer
// could not take yet are held in tick_pending, and several missed ticks collapse into one.
module fade_prescaler #(
  parameter int STEP_DIV = 4000
) (
  input  logic clk_400K,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic consume,
  output logic tick,
  output logic tick_pending
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_pending_q, tick_pending_d;

  assign tick         = en && (cnt_q == CW'(STEP_DIV - 1));
  assign tick_pending = tick_pending_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_pending_d = (tick_pending_q || tick) && !consume && !clr;
  end

  always_ff @(posedge clk_400K) begin
    if (reset) begin
      cnt_q          <= '0;
      tick_pending_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      tick_pending_q <= tick_pending_d;
    end
  end

endmodule

// File: rtl/led_fade_sequencer.sv
// Bus master breathing REG_PWM0..NUM_CH-1 with a shared triangle-wave duty; yields the bus to the host between passes.
// LED_FADE_PHASE_EN: channel n is written with duty + n*PHASE (mod 256) instead of duty.
module led_fade_sequencer
  import led_driver_pkg::*;
#(
  parameter int                   STEP_DIV    = 4000,
  parameter int                   NUM_CH      = 4,
  parameter logic [DATA_BITS-1:0] LEDOUT_INIT = 8'hAA
`ifdef LED_FADE_PHASE_EN
  ,
  parameter logic [DATA_BITS-1:0] PHASE       = 8'h40
`endif
) (
  input  logic                 clk_400K,
  input  logic                 reset,
  input  logic                 run,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic [DATA_BITS-1:0] step,
  input  logic                 host_req,
  output logic                 host_gnt,
  output logic                 bus_oe,
  output reg_enum_t            bus_addr,
  output logic [DATA_BITS-1:0] bus_data,
  output logic                 bus_w_en,
  output logic                 busy,
  output logic [DATA_BITS-1:0] duty
);

  localparam int                   CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DATA_BITS-1:0] DUTY_MAX = '1;

  fade_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] duty_q, duty_d, duty_upd;
  logic                 dir_q, dir_d, dir_upd;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic                 run_q, run_d;
  logic                 host_gnt_q, host_gnt_d;
  logic                 tick, tick_pending, start, wait_exit, host_hold, at_boundary;
  logic [CH_W-1:0]      ch_idx;
  logic [DATA_BITS-1:0] ch_data;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  // mask_q holds the channels still to be written in this pass; the lowest one is next.
  assign ch_idx = lowest_set(mask_q);

`ifdef LED_FADE_PHASE_EN
  assign ch_data = duty_q + DATA_BITS'(ch_idx) * PHASE;
`else
  assign ch_data = duty_q;
`endif

  fade_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk_400K     (clk_400K),
    .reset        (reset),
    .en           (state_q != FS_IDLE),
    .clr          (start),
    .consume      (wait_exit),
    .tick         (tick),
    .tick_pending (tick_pending)
  );

  // The host can only take the bus where no write is in flight; once granted the FSM freezes.
  assign at_boundary = (state_q == FS_IDLE) || (state_q == FS_WAIT_TICK);
  assign host_gnt_d  = host_req && (host_gnt_q || at_boundary);
  assign host_hold   = host_gnt_q || (host_req && at_boundary);
  assign run_d       = run;

  always_comb begin
    duty_upd = duty_q;
    dir_upd  = dir_q;
    if (dir_q == FADE_DIR_UP) begin
      if (duty_q > DUTY_MAX - step) begin
        duty_upd = DUTY_MAX;
        dir_upd  = FADE_DIR_DOWN;
      end else begin
        duty_upd = duty_q + step;
      end
    end else if (duty_q < step) begin
      duty_upd = '0;
      dir_upd  = FADE_DIR_UP;
    end else begin
      duty_upd = duty_q - step;
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    start     = 1'b0;
    wait_exit = 1'b0;
    if (!host_hold) begin
      case (state_q)
        FS_IDLE: begin
          if (run && !run_q) begin
            state_d = FS_INIT_SETUP;
            start   = 1'b1;
          end
        end
        FS_INIT_SETUP: state_d = FS_INIT_WEN;
        FS_INIT_WEN:   state_d = run ? FS_WAIT_TICK : FS_IDLE;
        FS_WAIT_TICK: begin
          if (!run) begin
            state_d = FS_IDLE;
          end else if (tick || tick_pending) begin
            wait_exit = 1'b1;
            duty_d    = duty_upd;
            dir_d     = dir_upd;
            mask_d    = ch_mask;
            state_d   = (ch_mask != '0) ? FS_CH_SETUP : FS_WAIT_TICK;
          end
        end
        FS_CH_SETUP: state_d = FS_CH_WEN;
        FS_CH_WEN: begin
          mask_d = mask_q & ~(NUM_CH'(1) << ch_idx);
          if (!run)                state_d = FS_IDLE;
          else if (mask_d == '0)   state_d = FS_WAIT_TICK;
          else                     state_d = FS_CH_SETUP;
        end
        default: state_d = FS_IDLE;
      endcase
    end
  end

  always_comb begin
    bus_oe   = 1'b0;
    bus_w_en = 1'b0;
    bus_addr = REG_PWM0;
    bus_data = '0;
    case (state_q)
      FS_INIT_SETUP, FS_INIT_WEN: begin
        bus_oe   = 1'b1;
        bus_w_en = (state_q == FS_INIT_WEN);
        bus_addr = REG_LEDOUT;
        bus_data = LEDOUT_INIT;
      end
      FS_CH_SETUP, FS_CH_WEN: begin
        bus_oe   = 1'b1;
        bus_w_en = (state_q == FS_CH_WEN);
        bus_addr = reg_enum_t'(4'(REG_PWM0) + 4'(ch_idx));
        bus_data = ch_data;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != FS_IDLE);
  assign host_gnt = host_gnt_q;
  assign duty     = duty_q;

  always_ff @(posedge clk_400K) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      duty_q     <= '0;
      dir_q      <= FADE_DIR_UP;
      mask_q     <= '0;
      run_q      <= 1'b0;
      host_gnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      run_q      <= run_d;
      host_gnt_q <= host_gnt_d;
    end
  end

endmodule
